calc_entry: RTL and testbench
=============================

CALC_ENTRY -- requirements
Module: calc_entry

Interface
REQ-001 SHALL expose parameter NDIG, default 4, meaning BCD digits per operand and per result.
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port: btn_press  in  1  key-valid level from keyboard scanner, held several cycles.
REQ-006 SHALL have ports: is_num, is_op, is_eq  in  1 each  key class, valid while btn_press high.
REQ-007 SHALL have port: num_val  in  4  BCD digit.
REQ-008 SHALL have port: op_val  in  2  operation: 1=add, 2=subtract, others ignored.
REQ-009 SHALL have port: disp_bcd  out  4*NDIG  packed BCD value to display.
REQ-010 SHALL have ports: disp_neg, ovf  out  1 each  result sign and overflow flags.
REQ-011 SHALL have ports: busy, result_valid  out  1 each  compute in progress; one-cycle result strobe.
REQ-012 SHALL have port: cur_op  out  2  stored pending operation.

Function
REQ-013 SHALL register btn_press; a key event SHALL occur only in a cycle where btn_press=1 and the registered copy=0 (one event per press regardless of hold length).
REQ-014 SHALL classify the event from is_eq, is_op, is_num sampled in the event cycle, with priority eq > op > num; an event with no flag set SHALL be ignored.
REQ-015 SHALL implement states ENTER_A, OP_WAIT, ENTER_B, COMPUTE, SHOW.
REQ-016 In ENTER_A, a num event SHALL shift the digit into A at the LSD (A <= A<<4 | num_val) while the digit count < NDIG; further digits SHALL be ignored.
REQ-017 In ENTER_A, an op event with op_val 1 or 2 SHALL store cur_op and go to OP_WAIT; eq events SHALL be ignored.
REQ-018 In OP_WAIT, a num event SHALL set B = digit, count = 1, and go to ENTER_B; an op event SHALL replace cur_op; eq SHALL be ignored.
REQ-019 In ENTER_B, a num event SHALL follow the REQ-016 shifting rules for B; eq SHALL go to COMPUTE; op SHALL be ignored.
REQ-020 COMPUTE SHALL process one digit per cycle, LSD first, for exactly NDIG cycles; busy=1 throughout; all key events SHALL be dropped.
REQ-021 For add, the result SHALL be A+B mod 10^NDIG, with ovf=1 on a final carry.
REQ-022 For subtract, the result SHALL be |A-B|; disp_neg=1 iff B>A, compared as unsigned packed values at COMPUTE entry; ovf=0.
REQ-023 For an eq event at cycle t: COMPUTE SHALL be in cycles t+1..t+NDIG; SHOW and result_valid=1 SHALL occur at t+NDIG+1; result_valid SHALL be high for exactly one cycle.
REQ-024 In SHOW, a num event SHALL clear A, B, flags, and cur_op, load A = digit, and go to ENTER_A.
REQ-025 In SHOW, an op event SHALL load A = result, store cur_op, and go to OP_WAIT (chaining), unless disp_neg or ovf is set, in which case it SHALL be ignored; eq SHALL be ignored.
REQ-026 disp_bcd SHALL show A in ENTER_A and OP_WAIT, B in ENTER_B, the previous display value in COMPUTE, and the result in SHOW.
REQ-027 disp_neg and ovf SHALL be 0 in every state except SHOW.

Reset
REQ-028 When rst_n=0 at a clock edge: state = ENTER_A; A, B, result, and digit counts = 0; all outputs = 0; the registered btn_press = 0.
REQ-029 Reset during COMPUTE SHALL abort the operation with no result_valid pulse.
REQ-030 A btn_press already high when reset releases SHALL produce an event at the first post-reset cycle it is seen high.

Structure
REQ-031 Package calc_pkg SHALL hold the op codes (OP_NONE=0, OP_ADD=1, OP_SUB=2), the state encoding, and the default NDIG.
REQ-032 Sub-module bcd_digit_addsub SHALL compute one BCD digit of add/subtract with carry/borrow in and out; calc_entry SHALL instantiate it once and iterate it over digits.

Verification
REQ-033 Keys 1,2,+,3,4,= -> disp_bcd=0x0046, disp_neg=0, ovf=0; result_valid exactly NDIG+1 cycles after the = event.
REQ-034 Keys 5,-,1,2,= -> disp_bcd=0x0007, disp_neg=1.
REQ-035 Keys 9,9,9,9,+,1,= -> disp_bcd=0x0000, ovf=1; a following + is ignored (state stays SHOW).
REQ-036 Keys 1,2,3,4,5 with each btn_press held 5 cycles -> disp_bcd=0x1234; each press counted once.
REQ-037 Keys 7,+,-,2,= -> 0x0005 (op replaced); then +,1,= -> 0x0006 (chaining).
REQ-038 rst_n low in the second COMPUTE cycle -> next cycle disp_bcd=0, state ENTER_A, no result_valid.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared op codes, FSM states and default sizing for the calculator entry block.
package calc_pkg;

    localparam int unsigned NDIG_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTER_B = 3'd2,
        COMPUTE = 3'd3,
        SHOW    = 3'd4
    } state_e;

    // Only add and subtract are accepted; any other op code is ignored.
    function automatic logic op_is_valid(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add or subtract with a ripple carry/borrow in and out.
module bcd_digit_addsub (
    input  logic       sub,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] raw;

    // Binary add/subtract followed by decimal correction of the digit.
    always_comb begin
        raw  = '0;
        d    = '0;
        cout = 1'b0;
        if (sub) begin
            raw = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
            if (raw[4]) begin
                d    = raw[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                d    = raw[3:0];
            end
        end else begin
            raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
            if (raw > 5'd9) begin
                d    = raw[3:0] + 4'd6;
                cout = 1'b1;
            end else begin
                d    = raw[3:0];
            end
        end
    end

endmodule

// File: rtl/calc_entry.sv
// Key-driven BCD calculator entry: operand entry, digit-serial add/subtract, result display.
module calc_entry
    import calc_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_press,
    input  logic                is_num,
    input  logic                is_op,
    input  logic                is_eq,
    input  logic [3:0]          num_val,
    input  logic [1:0]          op_val,
    output logic [4*NDIG-1:0]   disp_bcd,
    output logic                disp_neg,
    output logic                ovf,
    output logic                busy,
    output logic                result_valid,
    output logic [1:0]          cur_op
);

    localparam int unsigned   W        = 4 * NDIG;
    localparam int unsigned   CW       = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    state_e        state_q, state_d;
    op_e           cur_op_q, cur_op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  disp_q, disp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q, btn_d;
    logic          carry_q, carry_d;
    logic          sign_q, sign_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          rv_q, rv_d;

    logic          ev, ev_eq, ev_op, ev_num, op_ok, is_sub;
    logic [3:0]    dig;
    logic          dig_cout;

    // One event per press, classified with priority eq > op > num.
    always_comb begin
        ev     = btn_press & ~btn_q;
        ev_eq  = ev & is_eq;
        ev_op  = ev & ~is_eq & is_op;
        ev_num = ev & ~is_eq & ~is_op & is_num;
        op_ok  = op_is_valid(op_val);
        is_sub = (cur_op_q == OP_SUB);
    end

    // Single digit slice, fed the LSDs of the shifting operand registers during COMPUTE.
    bcd_digit_addsub u_digit (
        .sub  (is_sub),
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (carry_q),
        .d    (dig),
        .cout (dig_cout)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        btn_d    = btn_press;
        state_d  = state_q;
        cur_op_d = cur_op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sign_d   = sign_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        rv_d     = 1'b0;
        busy_d   = 1'b0;
        disp_d   = disp_q;

        case (state_q)
            ENTER_A: begin
                if (ev_num) begin
                    if (cnt_q < CNT_FULL) begin
                        a_d   = {a_q[W-5:0], num_val};
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (ev_op && op_ok) begin
                    cur_op_d = op_e'(op_val);
                    state_d  = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (ev_num) begin
                    b_d     = {{(W-4){1'b0}}, num_val};
                    cnt_d   = CNT_ONE;
                    state_d = ENTER_B;
                end else if (ev_op && op_ok) begin
                    cur_op_d = op_e'(op_val);
                end
            end
            ENTER_B: begin
                if (ev_eq) begin
                    // Subtract always runs larger minus smaller so no final borrow can occur.
                    state_d = COMPUTE;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    res_d   = '0;
                    sign_d  = 1'b0;
                    if (is_sub && (b_q > a_q)) begin
                        a_d    = b_q;
                        b_d    = a_q;
                        sign_d = 1'b1;
                    end
                end else if (ev_num && (cnt_q < CNT_FULL)) begin
                    b_d   = {b_q[W-5:0], num_val};
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            COMPUTE: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = {dig, res_q[W-1:4]};
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = SHOW;
                    rv_d    = 1'b1;
                    neg_d   = sign_q;
                    ovf_d   = (cur_op_q == OP_ADD) && dig_cout;
                end
            end
            SHOW: begin
                if (ev_num) begin
                    a_d      = {{(W-4){1'b0}}, num_val};
                    b_d      = '0;
                    res_d    = '0;
                    cnt_d    = CNT_ONE;
                    cur_op_d = OP_NONE;
                    sign_d   = 1'b0;
                    state_d  = ENTER_A;
                end else if (ev_op && op_ok && !neg_q && !ovf_q) begin
                    a_d      = res_q;
                    b_d      = '0;
                    cur_op_d = op_e'(op_val);
                    state_d  = OP_WAIT;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase

        busy_d = (state_d == COMPUTE);

        case (state_d)
            ENTER_A, OP_WAIT: disp_d = a_d;
            ENTER_B:          disp_d = b_d;
            SHOW:             disp_d = res_d;
            default:          disp_d = disp_q;
        endcase

        if (state_d != SHOW) begin
            neg_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ENTER_A;
            cur_op_q <= OP_NONE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            disp_q   <= '0;
            cnt_q    <= '0;
            btn_q    <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_op_q <= cur_op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            btn_q    <= btn_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
        end
    end

    assign disp_bcd     = disp_q;
    assign disp_neg     = neg_q;
    assign ovf          = ovf_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign cur_op       = cur_op_q;

endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry: decimal reference model, random and directed key sequences.
module tb_calc_entry;

    localparam int N = 4;
    localparam int P = 10 ** N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           btn_press = 1'b0;
    logic           is_num = 1'b0;
    logic           is_op = 1'b0;
    logic           is_eq = 1'b0;
    logic [3:0]     num_val = '0;
    logic [1:0]     op_val = '0;
    logic [4*N-1:0] disp_bcd;
    logic           disp_neg;
    logic           ovf;
    logic           busy;
    logic           result_valid;
    logic [1:0]     cur_op;

    calc_entry #(.NDIG(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_press    (btn_press),
        .is_num       (is_num),
        .is_op        (is_op),
        .is_eq        (is_eq),
        .num_val      (num_val),
        .op_val       (op_val),
        .disp_bcd     (disp_bcd),
        .disp_neg     (disp_neg),
        .ovf          (ovf),
        .busy         (busy),
        .result_valid (result_valid),
        .cur_op       (cur_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int rv_seen = 0;

    typedef struct {
        logic [4*N-1:0] bcd;
        logic           neg;
        logic           ovf;
        int             when;
    } exp_t;
    exp_t sb[$];

    // Reference model: calculator state as plain decimal integers.
    int m_ph;      // 0 entering A, 1 waiting for B, 2 entering B, 3 result
    int m_a, m_b, m_acnt, m_bcnt, m_op, m_res, m_cmp_end;
    bit m_neg, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_ph = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0;
        m_op = 0; m_res = 0; m_cmp_end = -1; m_neg = 0; m_ovf = 0;
        sb.delete();
    endfunction

    // f = {eq, op, num}; ev_edge is the cycle number of the edge that sees the press.
    function automatic void model_key(input logic [2:0] f, input int v, input int op, input int ev_edge);
        exp_t e;
        if (m_ph == 3 && ev_edge <= m_cmp_end) return;
        if (f[2]) begin
            if (m_ph == 2) begin
                if (m_op == 1) begin
                    m_res = (m_a + m_b) % P;
                    m_ovf = (m_a + m_b) >= P;
                    m_neg = 0;
                end else begin
                    m_neg = m_b > m_a;
                    m_res = m_neg ? m_b - m_a : m_a - m_b;
                    m_ovf = 0;
                end
                m_ph = 3;
                m_cmp_end = ev_edge + N;
                e.bcd = to_bcd(m_res);
                e.neg = m_neg;
                e.ovf = m_ovf;
                e.when = ev_edge + N;
                sb.push_back(e);
            end
        end else if (f[1]) begin
            if (op == 1 || op == 2) begin
                case (m_ph)
                    0: begin m_op = op; m_ph = 1; end
                    1: m_op = op;
                    3: if (!m_neg && !m_ovf) begin m_a = m_res; m_op = op; m_ph = 1; end
                    default: ;
                endcase
            end
        end else if (f[0]) begin
            case (m_ph)
                0: if (m_acnt < N) begin m_a = m_a * 10 + v; m_acnt++; end
                1: begin m_b = v; m_bcnt = 1; m_ph = 2; end
                2: if (m_bcnt < N) begin m_b = m_b * 10 + v; m_bcnt++; end
                3: begin
                    m_a = v; m_acnt = 1; m_b = 0; m_op = 0;
                    m_neg = 0; m_ovf = 0; m_ph = 0;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_state(input string tag);
        logic [4*N-1:0] ed;
        ed = (m_ph == 2) ? to_bcd(m_b) : (m_ph == 3) ? to_bcd(m_res) : to_bcd(m_a);
        chk({tag, "/disp"}, 32'(disp_bcd), 32'(ed));
        chk({tag, "/neg"}, 32'(disp_neg), (m_ph == 3) ? 32'(m_neg) : 32'd0);
        chk({tag, "/ovf"}, 32'(ovf), (m_ph == 3) ? 32'(m_ovf) : 32'd0);
        chk({tag, "/cur_op"}, 32'(cur_op), 32'(m_op));
        chk({tag, "/busy"}, 32'(busy), 32'd0);
    endtask

    task automatic press(input logic [2:0] f, input int v, input int op, input int hold, input int gap);
        @(negedge clk);
        is_eq = f[2]; is_op = f[1]; is_num = f[0];
        num_val = 4'(v); op_val = 2'(op);
        btn_press = 1'b1;
        model_key(f, v, op, cyc + 1);
        repeat (hold) @(negedge clk);
        btn_press = 1'b0; is_eq = 1'b0; is_op = 1'b0; is_num = 1'b0;
        repeat (gap) @(negedge clk);
        if (!(m_ph == 3 && cyc < m_cmp_end)) check_state("key");
    endtask

    task automatic knum(input int v);  press(3'b001, v, 0, 2, 2);     endtask
    task automatic kop(input int op);  press(3'b010, 0, op, 2, 2);    endtask
    task automatic keq();              press(3'b100, 0, 0, 2, N + 3); endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_press = 1'b0; is_eq = 1'b0; is_op = 1'b0; is_num = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: pops the scoreboard on each result strobe and checks value and timing.
    initial begin
        bit rv_prev;
        exp_t e;
        rv_prev = 0;
        forever begin
            @(negedge clk);
            if (rv_prev) begin
                chk("rv_one_cycle", 32'(result_valid), 32'd0);
            end else if (result_valid) begin
                rv_seen++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rv_unexpected: result_valid=1 with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("res_disp", 32'(disp_bcd), 32'(e.bcd));
                    chk("res_neg", 32'(disp_neg), 32'(e.neg));
                    chk("res_ovf", 32'(ovf), 32'(e.ovf));
                    chk("res_cycle", 32'(cyc), 32'(e.when));
                end
            end
            rv_prev = result_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_base;
        int r;
        logic [2:0] f;
        model_reset();

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_disp", 32'(disp_bcd), 32'd0);
        chk("rst_neg", 32'(disp_neg), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_cur_op", 32'(cur_op), 32'd0);

        // Key held across reset release gives one event on the first free cycle.
        is_num = 1'b1; num_val = 4'd3; btn_press = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_key(3'b001, 3, 0, cyc + 1);
        repeat (2) @(negedge clk);
        btn_press = 1'b0; is_num = 1'b0;
        repeat (2) @(negedge clk);
        check_state("rst_release");
        chk("rst_release_const", 32'(disp_bcd), 32'h0003);

        do_reset();
        knum(1); knum(2); kop(1); knum(3); knum(4); keq();
        chk("add_46", 32'(disp_bcd), 32'h0046);

        do_reset();
        knum(5); kop(2); knum(1); knum(2); keq();
        chk("sub_7", 32'(disp_bcd), 32'h0007);
        chk("sub_neg", 32'(disp_neg), 32'd1);

        do_reset();
        knum(9); knum(9); knum(9); knum(9); kop(1); knum(1); keq();
        chk("ovf_disp", 32'(disp_bcd), 32'h0000);
        chk("ovf_flag", 32'(ovf), 32'd1);
        kop(1);
        chk("ovf_hold_flag", 32'(ovf), 32'd1);

        do_reset();
        for (int d = 1; d <= 5; d++) press(3'b001, d, 0, 5, 2);
        chk("long_hold_1234", 32'(disp_bcd), 32'h1234);

        do_reset();
        knum(7); kop(1); kop(2); knum(2); keq();
        chk("op_replace_5", 32'(disp_bcd), 32'h0005);
        kop(1); knum(1); keq();
        chk("chain_6", 32'(disp_bcd), 32'h0006);

        // Reset in the second COMPUTE cycle aborts the result.
        do_reset();
        knum(1); kop(1); knum(2);
        rv_base = rv_seen;
        press(3'b100, 0, 0, 2, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_disp", 32'(disp_bcd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rv", 32'(result_valid), 32'd0);
        model_reset();
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);
        chk("abort_no_rv", 32'(rv_seen), 32'(rv_base));
        knum(5);
        chk("abort_enter_a", 32'(disp_bcd), 32'h0005);

        // Random key stream, including keys dropped during COMPUTE and multi-flag keys.
        do_reset();
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      f = 3'b001;
            else if (r <= 6) f = 3'b010;
            else if (r == 7) f = 3'b100;
            else if (r == 8) f = 3'($urandom_range(0, 7));
            else             f = 3'b000;
            press(f, $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(1, 6),
                  f[2] ? $urandom_range(1, N + 4) : $urandom_range(1, 3));
        end

        repeat (N + 5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
